// File: rtl/cmdin_queue_sched.sv
// Round-robin scheduler that drains the per-accelerator command subqueues of the shared CmdIn
// BRAM onto the cmdin_out stream, one command in flight at a time.
module cmdin_queue_sched #(
    parameter int unsigned MAX_ACCS           = 16,
    parameter int unsigned CMDIN_SUBQUEUE_LEN = 64,
    localparam int unsigned AW = $clog2(MAX_ACCS),
    localparam int unsigned PW = $clog2(CMDIN_SUBQUEUE_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          cmdin_queue_clk,
    output logic          cmdin_queue_rst,
    output logic          cmdin_queue_en,
    output logic [7:0]    cmdin_queue_we,
    output logic [31:0]   cmdin_queue_addr,
    output logic [63:0]   cmdin_queue_din,
    input  logic [63:0]   cmdin_queue_dout,
    output logic          cmdin_out_tvalid,
    input  logic          cmdin_out_tready,
    output logic [AW-1:0] cmdin_out_tdest,
    output logic [63:0]   cmdin_out_tdata,
    output logic          cmdin_out_tlast,
    input  logic          acc_done_valid,
    input  logic [AW-1:0] acc_done_id,
    output logic          cmd_error
);

    typedef enum logic [2:0] {StScan, StRdHdr, StSend, StRdArg, StClear, StNext} state_e;

    state_e              state_q;
    logic [AW-1:0]       cur_q;
    logic [AW-1:0]       cur_next;
    logic [PW-1:0]       rp_q [MAX_ACCS];
    logic [MAX_ACCS-1:0] busy_q;
    logic [MAX_ACCS-1:0] busy_d;
    logic [PW-1:0]       n_q;
    logic [PW-1:0]       k_q;
    logic [PW-1:0]       adv_q;
    logic [PW-1:0]       rp_cur;
    logic [PW-1:0]       arg_ptr;
    logic [PW-1:0]       word_ptr;
    logic                handshake;
    logic                arg_req;
    logic [7:0]          hdr_n;

    assign cmdin_queue_clk = clk;
    assign cmdin_queue_rst = rst;

    assign rp_cur    = rp_q[cur_q];
    assign arg_ptr   = rp_cur + k_q + PW'(1);
    assign handshake = cmdin_out_tvalid && cmdin_out_tready;
    assign arg_req   = (state_q == StSend) && handshake && (k_q != n_q);
    assign cur_next  = (cur_q == AW'(MAX_ACCS - 1)) ? '0 : cur_q + AW'(1);
    assign hdr_n     = cmdin_queue_dout[15:8];

    // BRAM port is decoded from state so the read issued here returns in the following state.
    always_comb begin
        cmdin_queue_en = 1'b0;
        word_ptr       = rp_cur;
        if (!rst) begin
            case (state_q)
                StScan:  cmdin_queue_en = !busy_q[cur_q];
                StSend: begin
                    cmdin_queue_en = arg_req;
                    if (arg_req) word_ptr = arg_ptr;
                end
                StClear: cmdin_queue_en = 1'b1;
                default: cmdin_queue_en = 1'b0;
            endcase
        end
    end

    assign cmdin_queue_we   = (cmdin_queue_en && state_q == StClear) ? 8'hFF : 8'h00;
    assign cmdin_queue_din  = '0;
    assign cmdin_queue_addr = 32'({cur_q, word_ptr, 3'b000});

    // Completion of the last beat wins over a done pulse for the same accelerator.
    always_comb begin
        busy_d = busy_q;
        if (acc_done_valid) busy_d[acc_done_id] = 1'b0;
        if (state_q == StSend && handshake && cmdin_out_tlast) busy_d[cur_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StScan;
            cur_q            <= '0;
            busy_q           <= '0;
            n_q              <= '0;
            k_q              <= '0;
            adv_q            <= '0;
            for (int unsigned a = 0; a < MAX_ACCS; a++) rp_q[a] <= '0;
            cmd_error        <= 1'b0;
            cmdin_out_tvalid <= 1'b0;
            cmdin_out_tdest  <= '0;
            cmdin_out_tdata  <= '0;
            cmdin_out_tlast  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                StScan: begin
                    if (busy_q[cur_q]) cur_q <= cur_next;
                    else state_q <= StRdHdr;
                end
                StRdHdr: begin
                    if (!cmdin_queue_dout[63]) begin
                        state_q <= StNext;
                    end else if (hdr_n > 8'(CMDIN_SUBQUEUE_LEN - 1)) begin
                        cmd_error <= 1'b1;
                        adv_q     <= PW'(1);
                        state_q   <= StClear;
                    end else begin
                        n_q              <= hdr_n[PW-1:0];
                        k_q              <= '0;
                        cmdin_out_tvalid <= 1'b1;
                        cmdin_out_tdest  <= cur_q;
                        cmdin_out_tdata  <= cmdin_queue_dout;
                        cmdin_out_tlast  <= (hdr_n == 8'd0);
                        state_q          <= StSend;
                    end
                end
                StSend: begin
                    if (handshake) begin
                        cmdin_out_tvalid <= 1'b0;
                        cmdin_out_tlast  <= 1'b0;
                        if (k_q == n_q) begin
                            adv_q   <= n_q + PW'(1);
                            state_q <= StClear;
                        end else begin
                            state_q <= StRdArg;
                        end
                    end
                end
                StRdArg: begin
                    k_q              <= k_q + PW'(1);
                    cmdin_out_tvalid <= 1'b1;
                    cmdin_out_tdata  <= cmdin_queue_dout;
                    cmdin_out_tlast  <= (k_q + PW'(1) == n_q);
                    state_q          <= StSend;
                end
                StClear: begin
                    rp_q[cur_q] <= rp_cur + adv_q;
                    state_q     <= StNext;
                end
                StNext: begin
                    cur_q   <= cur_next;
                    state_q <= StScan;
                end
                default: state_q <= StScan;
            endcase
        end
    end

endmodule

// File: tb/tb_cmdin_queue_sched.sv
// Scoreboard bench for cmdin_queue_sched: a BRAM model backs the queue port and every accepted
// stream beat is compared against beats queued when the command was written.
module tb_cmdin_queue_sched;

    localparam int unsigned MAX_ACCS = 16;
    localparam int unsigned LEN      = 64;
    localparam int unsigned AW       = 4;
    localparam int unsigned WORDS    = MAX_ACCS * LEN;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [63:0]   data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmdin_queue_clk;
    logic          cmdin_queue_rst;
    logic          cmdin_queue_en;
    logic [7:0]    cmdin_queue_we;
    logic [31:0]   cmdin_queue_addr;
    logic [63:0]   cmdin_queue_din;
    logic [63:0]   cmdin_queue_dout = '0;
    logic          cmdin_out_tvalid;
    logic          cmdin_out_tready = 1'b0;
    logic [AW-1:0] cmdin_out_tdest;
    logic [63:0]   cmdin_out_tdata;
    logic          cmdin_out_tlast;
    logic          acc_done_valid = 1'b0;
    logic [AW-1:0] acc_done_id = '0;
    logic          cmd_error;

    logic [63:0] mem [WORDS] = '{default: 64'h0};
    logic        host_we   = 1'b0;
    logic [9:0]  host_idx  = '0;
    logic [63:0] host_data = '0;

    logic  ready_hold = 1'b1;
    logic  rand_mode  = 1'b0;
    beat_t expq[$];
    int    checks     = 0;
    int    passes     = 0;
    int    beats_seen = 0;

    cmdin_queue_sched #(
        .MAX_ACCS          (MAX_ACCS),
        .CMDIN_SUBQUEUE_LEN(LEN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmdin_queue_clk (cmdin_queue_clk),
        .cmdin_queue_rst (cmdin_queue_rst),
        .cmdin_queue_en  (cmdin_queue_en),
        .cmdin_queue_we  (cmdin_queue_we),
        .cmdin_queue_addr(cmdin_queue_addr),
        .cmdin_queue_din (cmdin_queue_din),
        .cmdin_queue_dout(cmdin_queue_dout),
        .cmdin_out_tvalid(cmdin_out_tvalid),
        .cmdin_out_tready(cmdin_out_tready),
        .cmdin_out_tdest (cmdin_out_tdest),
        .cmdin_out_tdata (cmdin_out_tdata),
        .cmdin_out_tlast (cmdin_out_tlast),
        .acc_done_valid  (acc_done_valid),
        .acc_done_id     (acc_done_id),
        .cmd_error       (cmd_error)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle read latency plus a host write port.
    always @(posedge clk) begin
        if (host_we) mem[host_idx] <= host_data;
        if (cmdin_queue_en) begin
            if (cmdin_queue_we == 8'hFF) mem[cmdin_queue_addr[12:3]] <= cmdin_queue_din;
            cmdin_queue_dout <= mem[cmdin_queue_addr[12:3]];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_hdr(input int acc, input int n, input int tag);
        return 64'h8000_0000_0000_0000 | (64'(tag) << 16) | (64'(n) << 8) | 64'(acc);
    endfunction

    function automatic logic [63:0] mk_arg(input int tag, input int i);
        return (64'(tag) << 16) | 64'(i + 1);
    endfunction

    task automatic host_write(input int idx, input logic [63:0] data);
        host_idx  = 10'(idx);
        host_data = data;
        host_we   = 1'b1;
        step(1);
        host_we   = 1'b0;
    endtask

    task automatic write_cmd(input int acc, input int rp, input int n, input int tag);
        for (int i = 0; i < n; i++) host_write(acc * LEN + (rp + 1 + i) % LEN, mk_arg(tag, i));
        host_write(acc * LEN + rp, mk_hdr(acc, n, tag));
    endtask

    task automatic push_cmd(input int acc, input int n, input int tag);
        beat_t b;
        b = {AW'(acc), mk_hdr(acc, n, tag), (n == 0)};
        expq.push_back(b);
        for (int i = 0; i < n; i++) begin
            b = {AW'(acc), mk_arg(tag, i), (i == n - 1)};
            expq.push_back(b);
        end
    endtask

    task automatic issue_cmd(input int acc, input int rp, input int n, input int tag);
        push_cmd(acc, n, tag);
        write_cmd(acc, rp, n, tag);
    endtask

    task automatic pulse_done(input int id);
        acc_done_id    = AW'(id);
        acc_done_valid = 1'b1;
        step(1);
        acc_done_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        while (expq.size() != 0 && cyc < budget) begin
            step(1);
            cyc++;
        end
        checks++;
        if (expq.size() != 0) begin
            $display("FAIL drain: %0d beats outstanding, required 0", expq.size());
            expq.delete();
        end else passes++;
        step(5);
    endtask

    task automatic wait_tvalid(input int dest, input int budget);
        int cyc = 0;
        while (!(cmdin_out_tvalid && cmdin_out_tdest == AW'(dest)) && cyc < budget) begin
            step(1);
            cyc++;
        end
        checks++;
        if (!(cmdin_out_tvalid && cmdin_out_tdest == AW'(dest)))
            $display("FAIL wait_tvalid: no beat for dest %0d within %0d cycles", dest, budget);
        else passes++;
    endtask

    task automatic check_rp(input int acc, input logic [5:0] exp_rp);
        checks++;
        if (dut.rp_q[acc] !== exp_rp)
            $display("FAIL rp[%0d]: got %0d, required %0d", acc, dut.rp_q[acc], exp_rp);
        else passes++;
    endtask

    // Samples on the falling edge; inputs only change just after the rising edge.
    task automatic scoreboard_monitor();
        beat_t got;
        beat_t exp_b;
        beat_t held_b;
        logic  held;
        held   = 1'b0;
        held_b = '0;
        forever begin
            @(negedge clk);
            got = {cmdin_out_tdest, cmdin_out_tdata, cmdin_out_tlast};
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (!cmdin_out_tvalid || got !== held_b)
                        $display("FAIL stall_hold: tvalid=%0b beat=%h, required tvalid=1 beat=%h",
                                 cmdin_out_tvalid, got, held_b);
                    else passes++;
                end
                if (cmdin_out_tvalid && cmdin_out_tready) begin
                    beats_seen++;
                    checks++;
                    if (expq.size() == 0) begin
                        $display("FAIL beat_unexpected: got %h, required no beat", got);
                    end else begin
                        exp_b = expq.pop_front();
                        if (got !== exp_b)
                            $display("FAIL beat: got dest=%0d data=%h last=%0b, required dest=%0d data=%h last=%0b",
                                     got.dest, got.data, got.last, exp_b.dest, exp_b.data, exp_b.last);
                        else passes++;
                    end
                end
                held   = cmdin_out_tvalid && !cmdin_out_tready;
                held_b = got;
            end
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            cmdin_out_tready = rand_mode ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({cmdin_queue_en, cmdin_queue_we, cmdin_queue_addr, cmdin_queue_din} !== '0)
            $display("FAIL reset_bram: en=%0b we=%h addr=%h din=%h, required all 0",
                     cmdin_queue_en, cmdin_queue_we, cmdin_queue_addr, cmdin_queue_din);
        else passes++;
        checks++;
        if ({cmdin_out_tvalid, cmdin_out_tdest, cmdin_out_tdata, cmdin_out_tlast} !== '0)
            $display("FAIL reset_stream: tvalid=%0b tdest=%0d tdata=%h tlast=%0b, required all 0",
                     cmdin_out_tvalid, cmdin_out_tdest, cmdin_out_tdata, cmdin_out_tlast);
        else passes++;
        checks++;
        if (cmd_error !== 1'b0) $display("FAIL reset_error: got %0b, required 0", cmd_error);
        else passes++;
        checks++;
        if (cmdin_queue_rst !== 1'b1 || cmdin_queue_clk !== clk)
            $display("FAIL reset_passthru: rst=%0b clk=%0b, required rst=1 clk=%0b",
                     cmdin_queue_rst, cmdin_queue_clk, clk);
        else passes++;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        beat_t b;
        b = {AW'(0), 64'h8000_0000_0000_0200, 1'b0};
        expq.push_back(b);
        b = {AW'(0), 64'hA, 1'b0};
        expq.push_back(b);
        b = {AW'(0), 64'hB, 1'b1};
        expq.push_back(b);
        host_write(1, 64'hA);
        host_write(2, 64'hB);
        host_write(0, 64'h8000_0000_0000_0200);
        wait_drain(500);
        checks++;
        if (mem[0] !== 64'h0) $display("FAIL basic_clear: word0=%h, required 0", mem[0]);
        else passes++;
        check_rp(0, 6'd3);
        checks++;
        if (dut.busy_q[0] !== 1'b1) $display("FAIL basic_busy: got %0b, required 1", dut.busy_q[0]);
        else passes++;
        pulse_done(0);
        step(1);
        checks++;
        if (dut.busy_q[0] !== 1'b0)
            $display("FAIL basic_done: busy=%0b, required 0", dut.busy_q[0]);
        else passes++;
    endtask

    task automatic test_wrap_round_robin();
        issue_cmd(3, 0, 62, 'h31);
        wait_drain(3000);
        check_rp(3, 6'd63);
        pulse_done(3);
        issue_cmd(3, 63, 0, 'h32);
        wait_drain(500);
        check_rp(3, 6'd0);
        pulse_done(3);
        issue_cmd(3, 0, 61, 'h33);
        wait_drain(3000);
        check_rp(3, 6'd62);
        pulse_done(3);
        // Hold acc 3 in SEND so both new commands are seen with cur = 3.
        ready_hold = 1'b0;
        issue_cmd(3, 62, 2, 'h34);
        wait_tvalid(3, 500);
        issue_cmd(5, 0, 1, 'h50);
        issue_cmd(2, 0, 1, 'h20);
        ready_hold = 1'b1;
        wait_drain(1000);
        check_rp(3, 6'd1);
        check_rp(5, 6'd2);
        check_rp(2, 6'd2);
        pulse_done(3);
        pulse_done(5);
        pulse_done(2);
    endtask

    task automatic test_busy();
        int seen0;
        issue_cmd(1, 0, 1, 'h11);
        wait_drain(500);
        write_cmd(1, 2, 2, 'h12);
        seen0 = beats_seen;
        step(150);
        checks++;
        if (beats_seen != seen0)
            $display("FAIL busy_block: %0d beats sent, required 0", beats_seen - seen0);
        else passes++;
        check_rp(1, 6'd2);
        push_cmd(1, 2, 'h12);
        pulse_done(1);
        wait_drain(500);
        check_rp(1, 6'd5);
        pulse_done(1);
    endtask

    task automatic test_error();
        checks++;
        if (cmd_error !== 1'b0) $display("FAIL error_pre: got %0b, required 0", cmd_error);
        else passes++;
        host_write(7 * LEN, mk_hdr(7, 255, 'h70));
        step(120);
        checks++;
        if (cmd_error !== 1'b1) $display("FAIL error_set: got %0b, required 1", cmd_error);
        else passes++;
        checks++;
        if (mem[7 * LEN] !== 64'h0)
            $display("FAIL error_clear: word=%h, required 0", mem[7 * LEN]);
        else passes++;
        check_rp(7, 6'd1);
        issue_cmd(7, 1, 1, 'h71);
        wait_drain(500);
        checks++;
        if (cmd_error !== 1'b1) $display("FAIL error_sticky: got %0b, required 1", cmd_error);
        else passes++;
        pulse_done(7);
    endtask

    task automatic test_random_ready();
        rand_mode = 1'b1;
        issue_cmd(4, 0, 4, 'h40);
        wait_drain(2000);
        rand_mode  = 1'b0;
        ready_hold = 1'b1;
        step(2);
        check_rp(4, 6'd5);
        pulse_done(4);
    endtask

    task automatic test_reset_mid_command();
        logic [63:0] hdr_word;
        ready_hold = 1'b0;
        step(2);
        write_cmd(6, 0, 3, 'h60);
        wait_tvalid(6, 500);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmdin_out_tvalid, cmdin_out_tdest, cmdin_out_tdata, cmdin_out_tlast} !== '0)
            $display("FAIL midreset_stream: tvalid=%0b tdata=%h, required all 0",
                     cmdin_out_tvalid, cmdin_out_tdata);
        else passes++;
        checks++;
        if ({cmdin_queue_en, cmdin_queue_we, cmdin_queue_addr, cmd_error} !== '0)
            $display("FAIL midreset_port: en=%0b we=%h addr=%h err=%0b, required all 0",
                     cmdin_queue_en, cmdin_queue_we, cmdin_queue_addr, cmd_error);
        else passes++;
        step(2);
        rst = 1'b0;
        hdr_word = mem[6 * LEN];
        checks++;
        if (hdr_word !== mk_hdr(6, 3, 'h60))
            $display("FAIL midreset_hdr: word=%h, required %h", hdr_word, mk_hdr(6, 3, 'h60));
        else passes++;
        // The abandoned command is still valid, so it is resent from the top after reset.
        push_cmd(6, 3, 'h60);
        ready_hold = 1'b1;
        wait_drain(500);
        check_rp(6, 6'd4);
    endtask

    initial begin
        fork
            scoreboard_monitor();
            drive_ready();
        join_none
        test_reset();
        test_basic();
        test_wrap_round_robin();
        test_busy();
        test_error();
        test_random_ready();
        test_reset_mid_command();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cmdin_queue_sched.md
Name: cmdin_queue_sched

Overview:
- Round-robin scheduler that drains the per-accelerator command-in subqueues held in the shared CmdIn BRAM.
- The host writes commands into the BRAM. The block detects valid commands for idle accelerators, streams each one to its accelerator on the cmdin_out AXI-Stream, clears the header slot, and advances the subqueue read pointer.
- It is the sole owner of the CmdIn BRAM port inside the manager.

Parameters:
- MAX_ACCS, 16: number of accelerators and subqueues; AW = $clog2(MAX_ACCS).
- CMDIN_SUBQUEUE_LEN, 64: words per subqueue; must be a power of 2 and ≤ 256; PW = $clog2(CMDIN_SUBQUEUE_LEN).

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous reset, active-high
- cmdin_queue_clk  out  1  driven directly by clk
- cmdin_queue_rst  out  1  driven directly by rst
- cmdin_queue_en  out  1  BRAM enable
- cmdin_queue_we  out  8  byte write enables; all 1 or all 0
- cmdin_queue_addr  out  32  byte address = word index × 8
- cmdin_queue_din  out  64  write data
- cmdin_queue_dout  in  64  read data, valid the cycle after en
- cmdin_out_tvalid  out  1  command beat valid
- cmdin_out_tready  in  1  accelerator ready
- cmdin_out_tdest  out  AW  target accelerator
- cmdin_out_tdata  out  64  command beat
- cmdin_out_tlast  out  1  last beat of command
- acc_done_valid  in  1  single-cycle pulse: accelerator finished its command
- acc_done_id  in  AW  id of finished accelerator
- cmd_error  out  1  sticky; set on a malformed header

Behaviour:
- Layout: subqueue a occupies words a×LEN .. a×LEN+LEN−1. Each subqueue has a read pointer rp[a] (PW bits), wrapping modulo LEN.
- Header word: bit63 = valid, bits[15:8] = N argument words. The arguments follow the header at rp+1 .. rp+N, wrapping within the subqueue.
- Host writes all arguments before setting header valid.
- Reset: every output 0 except cmdin_queue_clk and cmdin_queue_rst; all rp = 0; all busy = 0; current index cur = 0; cmd_error = 0; state = SCAN. Reset mid-command abandons the command; tvalid drops asynchronously and the header is left valid.
- busy[a] is set when the tlast beat for a is accepted, and cleared on acc_done_valid with acc_done_id = a. If both happen in the same cycle for the same a, busy ends set.
- FSM states:
  - SCAN: if busy[cur], set cur = cur+1 (wrap) and stay. Otherwise assert en with address of word cur×LEN+rp[cur], go RD_HDR.
  - RD_HDR: latch dout into hdr.
    - bit63 = 0: go NEXT.
    - N > LEN−1: set cmd_error, go CLEAR with adv = 1.
    - Otherwise set k = 0 and go SEND.
  - SEND: drive tvalid with tdest = cur and tdata = hdr when k = 0, else the latched argument word. tlast = (k == N).
    - On tready: if k == N, go CLEAR with adv = N+1; else issue a read of word rp+k+1 (wrap), go RD_ARG.
    - tvalid, tdata, tdest and tlast stay stable until tready.
  - RD_ARG: latch dout, k = k+1, go SEND.
  - CLEAR: write 64'h0 to the header word (we = 8'hFF), rp[cur] += adv (mod LEN), go NEXT.
  - NEXT: cur = cur+1 (wrap at MAX_ACCS−1 → 0), go SCAN.
- Only one command is in flight at a time. An empty slot costs 3 cycles (SCAN, RD_HDR, NEXT).
- A command with N = 0 emits a single beat with tlast = 1.
- A BRAM access is never issued in SEND while tvalid is high and tready is low.

Test Plan:
- Acc 0: header at word 0 = 0x8000_0000_0000_0200 (N=2), args 0xA, 0xB; tready held 1 → beats hdr, 0xA, 0xB with tdest = 0 and tlast on 0xB only; word 0 then reads 0; rp[0] = 3; busy[0] = 1.
- Acc 3: valid N=0 header at rp = 63 (LEN=64) → one beat with tlast = 1; rp[3] wraps to 0. A following N=2 command at rp = 62 reads its args from words 63 and 0 of the subqueue.
- Acc 1 busy with a second command pending → not sent. Pulse acc_done_valid with id = 1 → sent on the next visit to acc 1.
- Valid commands in subqueues 2 and 5 with cur = 3 → 5 is served before 2, confirming round-robin order.
- Header with N = 0xFF → no beats; cmd_error = 1 and stays 1; header cleared; rp += 1.
- tready toggled randomly during a 4-arg command → beats arrive in order, data held stable while stalled, no duplicates. Asserting rst mid-command → all outputs 0 in the same cycle.
